reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register. Up to N requesters compete to load the register through a req/grant handshake. A hold counter stops any one requester from keeping the register when others are waiting. The block sits in front of the shared register and is the only path that writes it.

## Interface
- WIDTH, 8, data width of the shared register.
- N, 4, number of requesters (2..8).
- MAX_HOLD, 4, maximum consecutive granted cycles while another requester is waiting (1..255).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request, level-sensitive.
- wdata  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
- grant  output  N  one-hot grant, or all zero; registered.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  one-cycle pulse after each transfer.
- owner  output  $clog2(N)  index of the requester that last wrote q.

## Operation
- Internal state:
  - FSM {IDLE, BUSY}.
  - Round-robin pointer ptr (0..N-1).
  - Current owner index cur.
  - hold_cnt, 8 bits.
- Reset, asynchronous and immediate:
  - grant=0, q=0, q_valid=0, owner=0.
  - FSM=IDLE, ptr=0, cur=0, hold_cnt=0.
- Selection function sel(start): the first index with req high, searching start, start+1, … modulo N.
- Transfer: at an edge where grant[i]=1 and req[i]=1:
  - q <= wdata slice i, owner <= i, q_valid <= 1.
  - At every other edge, q_valid <= 0.
- IDLE behaviour at an edge:
  - If any req is high: cur <= sel(ptr), grant <= onehot(cur), hold_cnt <= 1, go to BUSY.
  - No transfer occurs at this edge, because grant was still 0.
- BUSY behaviour at an edge. Exactly one of these applies, in priority order:
  1. req[cur]=0 (release): no transfer. If another req is high, switch directly to sel(cur+1) with hold_cnt=1. Otherwise grant <= 0 and go to IDLE.
  2. req[cur]=1, hold_cnt==MAX_HOLD, and some other req is high (forced rotation): transfer for cur at this edge, then switch to sel(cur+1) with hold_cnt=1.
  3. req[cur]=1 otherwise: transfer, keep grant, hold_cnt <= min(hold_cnt+1, MAX_HOLD).
- Every grant change sets ptr <= (new cur)+1 mod N.
  - Entering IDLE leaves ptr unchanged.
- Width and arithmetic rules:
  - hold_cnt saturates at MAX_HOLD and never wraps.
  - ptr and cur wrap modulo N; this is explicit for non-power-of-two N.
- grant is never multi-hot.
- Changes in wdata for a non-granted requester have no effect.

## Timing
- From IDLE, with req[i] seen high at edge k:
  - grant[i]=1 after edge k.
  - First transfer at edge k+1: q and q_valid valid after k+1.
- Sustained grant gives one transfer per cycle, so q_valid stays high continuously.
- Handover gap:
  - Forced rotation has no idle cycle: the new owner's first transfer is at the edge after the switch.
  - Release costs one cycle with no transfer, because the owner's req is already low.
- Requester protocol: hold req and wdata stable until grant is seen; drop req after the last wanted transfer edge.
- Reset asserted mid-burst:
  - All outputs clear without waiting for clk.
  - After deassertion, arbitration restarts from ptr=0.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins.

## Test plan
- Reset: assert reset mid-cycle with req=4'b1111 → grant=0, q=0, q_valid=0, owner=0 immediately, and they stay so while reset is high.
- Single requester: N=4, MAX_HOLD=4, req=4'b0100, wdata2=8'hA5 for 3 cycles, then req=0.
  - grant=4'b0100 one edge after req.
  - q=8'hA5, owner=2, q_valid high for 3 cycles.
  - Then grant=0, q holds 8'hA5.
- Fair rotation: req=4'b1111 held, wdata_i=8'h10+i.
  - grant sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
  - q steps 10, 11, 12, 13 with q_valid continuously high after the first transfer.
- Release handover: owner 0 granted, req=4'b1011.
  - Drop req[0] → next grant is 4'b0010, after one cycle with no transfer.
  - Then drop req[1] → grant=4'b1000.
- Saturation: only req[3] held for 10 cycles → grant stays 4'b1000 with no gap, hold_cnt=4.
  - Raise req[0] → exactly one more transfer for 3, then grant=4'b0001.
- Restart after reset: reset during a burst owned by requester 2, then req=4'b1100 → first grant is 4'b0100, because ptr=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of a shared WIDTH-bit
// register. Requesters hand over through a registered one-hot grant. A hold
// counter forces rotation once the owner has held the register for MAX_HOLD
// cycles while someone else is waiting.
module reg_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     wdata,
  output logic [N-1:0]           grant,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [$clog2(N)-1:0]   owner
);

  localparam int IDX_W = $clog2(N);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] cur, cur_n;
  logic [7:0]       hold_cnt, hold_n;
  logic [N-1:0]     grant_n;
  logic             xfer;
  logic             others;
  logic             rotate;
  logic [WIDTH-1:0] slot [N];

  // Index increment that wraps at N, so non-power-of-two N stays in range.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // First requesting index found when searching from start upward, modulo N.
  function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] r,
                                           input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    logic             found;
    int               s;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(start) + i;
      if (s >= N) s = s - N;
      if (!found && r[IDX_W'(s)]) begin
        res   = IDX_W'(s);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Hold counter increment that saturates at MAX_HOLD instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] h);
    return (h >= HOLD_MAX) ? HOLD_MAX : h + 8'd1;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot[i] = wdata[i*WIDTH +: WIDTH];
  end

  // A transfer happens only where the registered grant meets a live request.
  assign xfer   = |(grant & req);
  assign others = |(req & ~onehot(cur));

  // Next-state logic: grant selection, rotation and hold counting.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur;
    hold_n  = hold_cnt;
    grant_n = grant;
    rotate  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          cur_n   = sel(req, ptr);
          grant_n = onehot(cur_n);
          hold_n  = 8'd1;
          ptr_n   = wrap_inc(cur_n);
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!req[cur]) begin
          // Owner released; hand over if anyone else wants it.
          if (|req) begin
            rotate = 1'b1;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (hold_cnt == HOLD_MAX && others) begin
          // Owner still transfers this edge, then must yield.
          rotate = 1'b1;
        end else begin
          hold_n = sat_inc(hold_cnt);
        end
        if (rotate) begin
          cur_n   = sel(req, wrap_inc(cur));
          grant_n = onehot(cur_n);
          hold_n  = 8'd1;
          ptr_n   = wrap_inc(cur_n);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cur      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      owner    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cur      <= cur_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      q_valid  <= xfer;
      if (xfer) begin
        q     <= slot[cur];
        owner <= cur;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N=4, WIDTH=8, MAX_HOLD=4). Expected
// transfers are queued as stimulus is applied and popped whenever q_valid
// is seen.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data [$];
  logic [1:0] exp_own  [$];

  reg_write_arbiter #(.WIDTH(8), .N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .q(q), .q_valid(q_valid), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] o, input int n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(d);
      exp_own.push_back(o);
    end
  endtask

  task automatic sb_check();
    logic [7:0] d;
    logic [1:0] o;
    if (!reset && q_valid) begin
      total++;
      assert (exp_data.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=q_valid q=%0h owner=%0d expected=no_transfer", q, owner);
      end
      if (exp_data.size() > 0) begin
        d = exp_data.pop_front();
        o = exp_own.pop_front();
        chk("sb_q", 32'(q), 32'(d));
        chk("sb_owner", 32'(owner), 32'(o));
      end
    end
  endtask

  // One clock edge, then settle at the falling edge and score any transfer.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      sb_check();
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;

    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qvalid", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    reset = 1'b0;
    tick(1);

    // Single requester 2, three transfers
    wdata[16 +: 8] = 8'hA5;
    req = 4'b0100;
    push(8'hA5, 2'd2, 3);
    tick(1);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_noxfer", 32'(q_valid), 32'h0);
    tick(1);
    chk("single_qv1", 32'(q_valid), 32'h1);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_owner", 32'(owner), 32'h2);
    wdata[8 +: 8] = 8'hFF;
    tick(2);
    chk("single_qv3", 32'(q_valid), 32'h1);
    chk("single_q3", 32'(q), 32'hA5);
    req = 4'b0000;
    tick(1);
    chk("single_grant_off", 32'(grant), 32'h0);
    chk("single_qv_off", 32'(q_valid), 32'h0);
    chk("single_q_hold", 32'(q), 32'hA5);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("async_q", 32'(q), 32'h0);
    chk("async_owner", 32'(owner), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Fair rotation with all four requesting
    wdata = 32'h13121110;
    req   = 4'b1111;
    push(8'h10, 2'd0, 4);
    push(8'h11, 2'd1, 4);
    push(8'h12, 2'd2, 4);
    push(8'h13, 2'd3, 4);
    tick(1);
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rot_grant_%0d_%0d", g, c), 32'(grant), 32'(1 << g));
        if (g != 0 || c != 0) chk($sformatf("rot_qv_%0d_%0d", g, c), 32'(q_valid), 32'h1);
        tick(1);
      end
    end
    chk("rot_wrap_grant", 32'(grant), 32'h1);
    chk("rot_wrap_qv", 32'(q_valid), 32'h1);

    // Release handover: 0 -> 1 -> 3
    req = 4'b1011;
    push(8'h10, 2'd0, 1);
    tick(1);
    chk("rel_grant0", 32'(grant), 32'h1);
    req = 4'b1010;
    tick(1);
    chk("rel_grant1", 32'(grant), 32'h2);
    chk("rel_gap", 32'(q_valid), 32'h0);
    push(8'h11, 2'd1, 1);
    tick(1);
    chk("rel_xfer1", 32'(q_valid), 32'h1);
    req = 4'b1000;
    tick(1);
    chk("rel_grant3", 32'(grant), 32'h8);
    chk("rel_gap3", 32'(q_valid), 32'h0);

    // Saturation: requester 3 alone keeps the grant with no gaps
    push(8'h13, 2'd3, 10);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("sat_grant_%0d", i), 32'(grant), 32'h8);
      chk($sformatf("sat_qv_%0d", i), 32'(q_valid), 32'h1);
    end
    req = 4'b1001;
    push(8'h13, 2'd3, 1);
    push(8'h10, 2'd0, 1);
    tick(1);
    chk("sat_rot_grant", 32'(grant), 32'h1);
    chk("sat_last_owner", 32'(owner), 32'h3);
    tick(1);
    chk("sat_new_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    tick(1);
    chk("sat_idle_grant", 32'(grant), 32'h0);

    // Burst owned by requester 2, then reset mid-burst
    req = 4'b0100;
    push(8'h12, 2'd2, 2);
    tick(1);
    chk("burst_grant", 32'(grant), 32'h4);
    tick(2);
    chk("burst_owner", 32'(owner), 32'h2);
    req = 4'b1111;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_qv", 32'(q_valid), 32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    tick(2);
    chk("rst_hold_grant", 32'(grant), 32'h0);
    chk("rst_hold_q", 32'(q), 32'h0);
    chk("rst_hold_qv", 32'(q_valid), 32'h0);

    // Restart: ptr is back at 0, so requester 2 wins over 3
    req   = 4'b1100;
    reset = 1'b0;
    tick(1);
    chk("restart_grant", 32'(grant), 32'h4);
    push(8'h12, 2'd2, 1);
    tick(1);
    chk("restart_qv", 32'(q_valid), 32'h1);
    req = 4'b0000;
    tick(2);
    chk("restart_idle", 32'(grant), 32'h0);

    chk("sb_drained", 32'(exp_data.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
